// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipe: shadow EX/MEM/WB
// scoreboard, load-use stall, branch flush, EX forwarding and MDU freeze.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_is_mdu,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             mdu_start,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       is_mdu;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  typedef enum logic {IDLE, BUSY} mdu_state_t;

  localparam logic [3:0] CNT_LAST = 4'(MDU_LAT - 1);

  sb_entry_t  ex_q, mem_q, wb_q, id_entry;
  mdu_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mdu_done_q, mdu_done_d;
  logic       hold, mdu_fire, load_use;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign id_entry = '{valid: id_valid, dest: id_dest, reg_write: id_reg_write,
                      mem_read: id_mem_read, is_mdu: id_is_mdu, rs: id_rs, rt: id_rt};

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdu_done_d = mdu_done_q;
    mdu_fire   = 1'b0;
    hold       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_q.valid && ex_q.is_mdu && !mdu_done_q) begin
          mdu_fire = 1'b1;
          hold     = 1'b1;
          cnt_d    = 4'd1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        hold = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          mdu_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The finished op leaves EX on the next unfrozen edge, which re-arms the FSM.
    if (!hold) mdu_done_d = 1'b0;
  end

  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_q.dest)) ||
                     (id_use_rt && (id_rt == ex_q.dest)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    mdu_start   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      mdu_start  = mdu_fire;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input sb_entry_t mem_e,
                                         input sb_entry_t wb_e);
    if (mem_e.valid && mem_e.reg_write && (mem_e.dest != 5'd0) && (mem_e.dest == src))
      return 2'b10;
    if (wb_e.valid && wb_e.reg_write && (wb_e.dest != 5'd0) && (wb_e.dest == src))
      return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a     = rst ? 2'b00 : fwd_sel(ex_q.rs, mem_q, wb_q);
  assign fwd_b     = rst ? 2'b00 : fwd_sel(ex_q.rt, mem_q, wb_q);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a handful of control flops, not a RAM, so it is reset outright.
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      mdu_done_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mdu_done_q <= mdu_done_d;
      if (!hold) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= (idex_bubble || !id_valid) ? '0 : id_entry;
      end
      if ((hold || (load_use && !ex_branch_taken)) && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (ex_branch_taken && !hold && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a pipeline-level model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int unsigned MDU_LAT = 4;
  localparam int unsigned CNT_W   = 32;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_is_mdu;
  logic ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_dest;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mdu_start;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_mdu(id_is_mdu),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .mdu_start(mdu_start), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    bit v; bit [4:0] dest; bit [4:0] rs; bit [4:0] rt;
    bit use_rs; bit use_rt; bit rw; bit mr; bit mdu;
  } instr_t;

  typedef logic [73:0] obs_t;

  // Model: stg[0]=EX, stg[1]=MEM, stg[2]=WB; hold_left = freeze cycles remaining.
  instr_t stg[3];
  instr_t cur_id;
  instr_t feed[$];
  obs_t   exp_q[$];
  int     hold_left;
  bit     done_m;
  longint stall_m, flush_m;
  int     errors = 0, checks = 0, cyc = 0;

  function automatic instr_t nop();
    instr_t n;
    n = '{default: '0};
    return n;
  endfunction

  function automatic instr_t mk(bit [4:0] dest, bit [4:0] rs, bit [4:0] rt,
                                bit urs, bit urt, bit rw, bit mr, bit mdu);
    instr_t n;
    n = '{v: 1'b1, dest: dest, rs: rs, rt: rt, use_rs: urs, use_rt: urt,
          rw: rw, mr: mr, mdu: mdu};
    return n;
  endfunction

  function automatic bit [1:0] fwd_of(bit [4:0] src);
    for (int i = 1; i <= 2; i++)
      if (stg[i].v && stg[i].rw && stg[i].dest != 0 && stg[i].dest == src)
        return (i == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit hold_pending();
    return (hold_left > 0) || (stg[0].v && stg[0].mdu && !done_m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) stg[i] = nop();
    hold_left = 0; done_m = 0; stall_m = 0; flush_m = 0;
    cur_id = nop();
  endtask

  task automatic cycle(input bit r, input bit br);
    bit start, hold, lu, pcw, ifw, fl, bub, st;
    bit [1:0] fa, fb;
    @(posedge clk); #1;
    rst = r; ex_branch_taken = br;
    id_valid = cur_id.v; id_rs = cur_id.rs; id_rt = cur_id.rt;
    id_use_rs = cur_id.use_rs; id_use_rt = cur_id.use_rt; id_dest = cur_id.dest;
    id_reg_write = cur_id.rw; id_mem_read = cur_id.mr; id_is_mdu = cur_id.mdu;
    cyc++;
    start = !r && hold_left == 0 && stg[0].v && stg[0].mdu && !done_m;
    if (start) hold_left = MDU_LAT;
    hold = !r && hold_left > 0;
    lu = stg[0].v && stg[0].mr && stg[0].dest != 0 &&
         ((cur_id.use_rs && cur_id.rs == stg[0].dest) ||
          (cur_id.use_rt && cur_id.rt == stg[0].dest));
    fa = r ? 2'b00 : fwd_of(stg[0].rs);
    fb = r ? 2'b00 : fwd_of(stg[0].rt);
    st = 0;
    if (r)          begin pcw = 0; ifw = 0; fl = 1; bub = 1; end
    else if (hold)  begin pcw = 0; ifw = 0; fl = 0; bub = 0; st = start; end
    else if (br)    begin pcw = 1; ifw = 1; fl = 1; bub = 1; end
    else if (lu)    begin pcw = 0; ifw = 0; fl = 0; bub = 1; end
    else            begin pcw = 1; ifw = 1; fl = 0; bub = 0; end
    exp_q.push_back({pcw, ifw, fl, bub, hold, st, fa, fb,
                     stall_m[CNT_W-1:0], flush_m[CNT_W-1:0]});
    if (r) begin
      model_reset();
    end else begin
      if ((hold || (lu && !br)) && stall_m < CNT_MAX) stall_m++;
      if (br && !hold && flush_m < CNT_MAX) flush_m++;
      if (hold) begin
        hold_left--;
        if (hold_left == 0) done_m = 1;
      end else begin
        done_m = 0;
        stg[2] = stg[1];
        stg[1] = stg[0];
        stg[0] = (bub || !cur_id.v) ? nop() : cur_id;
      end
      if (fl)       cur_id = nop();
      else if (ifw) cur_id = (feed.size() > 0) ? feed.pop_front() : nop();
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  function automatic instr_t rnd_instr();
    instr_t n;
    n.v      = ($urandom_range(7) != 0);
    n.dest   = 5'($urandom_range(3));
    n.rs     = 5'($urandom_range(3));
    n.rt     = 5'($urandom_range(3));
    n.use_rs = 1'($urandom_range(1));
    n.use_rt = 1'($urandom_range(1));
    n.mdu    = ($urandom_range(11) == 0);
    n.mr     = !n.mdu && ($urandom_range(3) == 0);
    n.rw     = !n.mdu && (n.mr || 1'($urandom_range(1)));
    return n;
  endfunction

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  initial begin
    obs_t got, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mdu_start,
               fwd_a, fwd_b, stall_cnt, flush_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got pcw/ifw/fl/bub/hold/start=%b fa=%b fb=%b stall=%0d flush=%0d ; exp %b fa=%b fb=%b stall=%0d flush=%0d",
                   cyc, got[73:68], got[67:66], got[65:64], got[63:32], got[31:0],
                   e[73:68], e[67:66], e[65:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; ex_branch_taken = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_dest = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_is_mdu = 1'b0;
    model_reset();
    @(posedge clk);
    cycle(1'b1, 1'b0);
    drain(2);

    // lw $8 ; add $9,$8,$10
    feed.push_back(mk(5'd8, 5'd29, 5'd0, 1, 0, 1, 1, 0));
    feed.push_back(mk(5'd9, 5'd8, 5'd10, 1, 1, 1, 0, 0));
    drain(7);

    // ALU chain on $21 as rt: EX/MEM forward, then MEM/WB, then $0 never forwards.
    feed.push_back(mk(5'd21, 5'd1, 5'd2, 1, 1, 1, 0, 0));
    feed.push_back(mk(5'd22, 5'd3, 5'd21, 1, 1, 1, 0, 0));
    feed.push_back(mk(5'd21, 5'd1, 5'd2, 1, 1, 1, 0, 0));
    feed.push_back(mk(5'd7, 5'd4, 5'd5, 1, 1, 1, 0, 0));
    feed.push_back(mk(5'd22, 5'd3, 5'd21, 1, 1, 1, 0, 0));
    feed.push_back(mk(5'd0, 5'd1, 5'd2, 1, 1, 1, 0, 0));
    feed.push_back(mk(5'd22, 5'd0, 5'd0, 1, 1, 1, 0, 0));
    drain(10);

    // mult followed by a dependent-free ALU op
    feed.push_back(mk(5'd0, 5'd4, 5'd5, 1, 1, 0, 0, 1));
    feed.push_back(mk(5'd11, 5'd6, 5'd7, 1, 1, 1, 0, 0));
    drain(12);

    // Branch resolves taken exactly when ID holds a load-use consumer.
    feed.push_back(mk(5'd8, 5'd29, 5'd0, 1, 0, 1, 1, 0));
    feed.push_back(mk(5'd9, 5'd8, 5'd10, 1, 1, 1, 0, 0));
    for (int i = 0; i < 6; i++)
      cycle(1'b0, stg[0].v && stg[0].mr && cur_id.v && cur_id.use_rs &&
                  cur_id.rs == stg[0].dest);
    drain(4);

    // Reset in the second BUSY cycle of an MDU op.
    feed.push_back(mk(5'd0, 5'd4, 5'd5, 1, 1, 0, 0, 1));
    guard = 0;
    while (hold_left != MDU_LAT - 2 && guard < 20) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL mdu_busy_reach got guard=%0d required <20", guard);
    end
    cycle(1'b1, 1'b0);
    drain(4);

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      bit r, br;
      if (feed.size() < 2) feed.push_back(rnd_instr());
      r  = ($urandom_range(149) == 0);
      br = !hold_pending() && ($urandom_range(7) == 0);
      cycle(r, br);
    end
    drain(3);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
